// File: rtl/wide_add_sequencer.sv
// wide_add_sequencer: multi-cycle wide adder built around one DATA_SIZE-bit
// chunk adder. One request is accepted over in_valid/in_ready, processed one
// chunk per cycle (least-significant first, carry chained through a register),
// and returned over out_valid/out_ready.
//
// Optional feature macro: WIDE_ADD_SUB_EN
//   defined   -> sub input selects a-b (b inverted, initial carry 1)
//   undefined -> sub input ignored, block always computes a+b
module wide_add_sequencer #(
    parameter int unsigned DATA_SIZE = 16,
    parameter int unsigned NUM_WORDS = 4
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [DATA_SIZE*NUM_WORDS-1:0] a,
    input  logic [DATA_SIZE*NUM_WORDS-1:0] b,
    input  logic                           sub,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [DATA_SIZE*NUM_WORDS-1:0] sum,
    output logic                           cout,
    output logic                           busy
);

    localparam int unsigned W     = DATA_SIZE * NUM_WORDS;
    localparam int unsigned IDX_W = $clog2(NUM_WORDS);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t               state_q, state_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic                 carry_q, carry_d;
    logic [W-1:0]         sum_q, sum_d;
    logic                 cout_q, cout_d;
    logic [W-1:0]         a_q, b_q;

    logic                 accept;
    logic                 sub_eff;
    logic [DATA_SIZE-1:0] a_chunk, b_chunk, b_eff;
    logic [DATA_SIZE:0]   chunk_total;

    assign in_ready  = (state_q == IDLE) && !reset;
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign accept    = in_valid && in_ready;

`ifdef WIDE_ADD_SUB_EN
    logic sub_q;

    assign sub_eff = sub;
    assign b_eff   = b_chunk ^ {DATA_SIZE{sub_q}};

    // Capture the operation select together with the operands.
    always_ff @(posedge clk) begin
        if (accept) begin
            sub_q <= sub_eff;
        end
    end
`else
    logic unused_sub;

    assign unused_sub = sub;
    assign sub_eff    = 1'b0;
    assign b_eff      = b_chunk;
`endif

    // Operand registers: loaded on the accept edge only.
    // NOTE: no reset here on purpose; these are only read in RUN, which is
    // always preceded by a load, so resetting them would only cost area.
    always_ff @(posedge clk) begin
        if (accept) begin
            a_q <= a;
            b_q <= b;
        end
    end

    // Select the operand chunks addressed by idx and add them with the carry.
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        a_chunk = '0;
        b_chunk = '0;
        for (int i = 0; i < int'(NUM_WORDS); i++) begin
            if (idx_q == IDX_W'(i)) begin
                a_chunk = a_q[i*DATA_SIZE +: DATA_SIZE];
                b_chunk = b_q[i*DATA_SIZE +: DATA_SIZE];
            end
        end
        chunk_total = {1'b0, a_chunk} + {1'b0, b_eff} + {{DATA_SIZE{1'b0}}, carry_q};
    end

    // Next-state logic: sequence IDLE -> RUN (one chunk per cycle) -> DONE.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        sum_d   = sum_q;
        cout_d  = cout_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    idx_d   = '0;
                    carry_d = sub_eff;
                    state_d = RUN;
                end
            end
            RUN: begin
                for (int i = 0; i < int'(NUM_WORDS); i++) begin
                    if (idx_q == IDX_W'(i)) begin
                        sum_d[i*DATA_SIZE +: DATA_SIZE] = chunk_total[DATA_SIZE-1:0];
                    end
                end
                carry_d = chunk_total[DATA_SIZE];
                if (idx_q == IDX_W'(NUM_WORDS - 1)) begin
                    cout_d  = chunk_total[DATA_SIZE];
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and result registers with synchronous reset.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of process ordering.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
        end
    end

endmodule

// File: tb/tb_wide_add_sequencer.sv
// Self-checking bench for wide_add_sequencer (default 16x4 configuration).
// Expected results come from a full-width reference sum pushed to a queue on
// each accepted request and popped when the DUT presents its result.
module tb_wide_add_sequencer;

    localparam int DS = 16;
    localparam int NW = 4;
    localparam int W  = DS * NW;

`ifdef WIDE_ADD_SUB_EN
    localparam bit SUB_EN = 1'b1;
`else
    localparam bit SUB_EN = 1'b0;
`endif

    typedef struct packed {
        logic [W-1:0] sum;
        logic         cout;
    } result_t;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         busy;

    int      cyc    = 0;
    int      errors = 0;
    int      checks = 0;
    result_t exp_q[$];

    wide_add_sequencer #(
        .DATA_SIZE(DS),
        .NUM_WORDS(NW)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .sub      (sub),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .sum      (sum),
        .cout     (cout),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic result_t model(input logic [W-1:0] op_a, input logic [W-1:0] op_b,
                                      input logic op_sub);
        logic       eff;
        logic [W:0] total;
        eff   = op_sub & SUB_EN;
        total = {1'b0, op_a} + {1'b0, (eff ? ~op_b : op_b)} + {{W{1'b0}}, eff};
        return '{sum: total[W-1:0], cout: total[W]};
    endfunction

    // Called just after a falling edge; returns just after the falling edge
    // that follows the accept edge, with acc_cyc = index of the accept edge.
    task automatic send(input logic [W-1:0] op_a, input logic [W-1:0] op_b,
                        input logic op_sub, output int acc_cyc);
        a        = op_a;
        b        = op_b;
        sub      = op_sub;
        in_valid = 1'b1;
        for (int n = 0; n < 50 && !in_ready; n++) @(negedge clk);
        if (!in_ready) begin
            check("send_ready", W'(in_ready), W'(1));
            in_valid = 1'b0;
            acc_cyc  = -1;
            return;
        end
        @(posedge clk);
        exp_q.push_back(model(op_a, op_b, op_sub));
        @(negedge clk);
        acc_cyc  = cyc;
        in_valid = 1'b0;
    endtask

    task automatic compare_head(input string tag);
        result_t exp;
        if (exp_q.size() == 0) begin
            check({tag, "_sb_empty"}, W'(exp_q.size()), W'(1));
            return;
        end
        exp = exp_q.pop_front();
        check({tag, "_sum"}, sum, exp.sum);
        check({tag, "_cout"}, W'(cout), W'(exp.cout));
    endtask

    // Wait for a result, optionally stall the consumer, then handshake.
    task automatic receive(input string tag, input int acc_cyc, input int stall);
        int n = 0;
        while (!out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_valid"}, W'(out_valid), W'(1));
        if (!out_valid) return;
        if (acc_cyc >= 0) check({tag, "_latency"}, W'(cyc - acc_cyc), W'(NW));
        out_ready = 1'b0;
        for (int s = 0; s < stall; s++) begin
            if (exp_q.size() != 0) begin
                check({tag, "_stall_sum"}, sum, exp_q[0].sum);
                check({tag, "_stall_cout"}, W'(cout), W'(exp_q[0].cout));
            end
            check({tag, "_stall_valid"}, W'(out_valid), W'(1));
            check({tag, "_stall_in_ready"}, W'(in_ready), W'(0));
            @(negedge clk);
        end
        compare_head(tag);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, "_idle_busy"}, W'(busy), W'(0));
        check({tag, "_idle_valid"}, W'(out_valid), W'(0));
    endtask

    logic [W-1:0] bb_a[3];
    logic [W-1:0] bb_b[3];

    initial begin
        int acc;
        int hs;
        int sent;
        int got;
        int last_acc;
        bit upd;

        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        sub       = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_in_ready", W'(in_ready), W'(0));
        check("rst_out_valid", W'(out_valid), W'(0));
        check("rst_busy", W'(busy), W'(0));
        check("rst_sum", sum, W'(0));
        check("rst_cout", W'(cout), W'(0));
        reset = 1'b0;
        #1;
        check("rst_in_ready_after", W'(in_ready), W'(1));

        // Carry out of chunk 0 into chunk 1, latency check
        send(64'h0000_0000_0000_FFFF, 64'h1, 1'b0, acc);
        receive("carry16", acc, 0);
        check("carry16_const", sum, 64'h0000_0000_0001_0000);

        // Carry ripples through all chunks
        send(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, acc);
        receive("ripple", acc, 0);
        check("ripple_const_sum", sum, W'(0));
        check("ripple_const_cout", W'(cout), W'(1));

        // Consumer stall with a second request pending; operands change mid-run
        send(64'h0123_4567_89AB_CDEF, 64'h1111_1111_1111_1111, 1'b0, acc);
        a        = 64'h8000_0000_0000_0000;
        b        = 64'h8000_0000_0000_0001;
        in_valid = 1'b1;
        receive("stall", acc, 3);
        check("stall_const", sum, 64'h1234_5678_9ABC_DF00);
        hs = cyc;
        send(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0001, 1'b0, acc);
        check("second_accept_cycle", W'(acc), W'(hs + 1));
        receive("second", acc, 0);

        // Subtract requests (sub ignored in the add-only build)
        send(64'd5, 64'd7, 1'b1, acc);
        receive("sub_neg", acc, 0);
`ifdef WIDE_ADD_SUB_EN
        check("sub_neg_const", sum, 64'hFFFF_FFFF_FFFF_FFFE);
`else
        check("sub_neg_const", sum, 64'd12);
`endif
        check("sub_neg_cout_const", W'(cout), W'(0));
        send(64'd7, 64'd5, 1'b1, acc);
        receive("sub_pos", acc, 0);
`ifdef WIDE_ADD_SUB_EN
        check("sub_pos_const", sum, 64'd2);
        check("sub_pos_cout_const", W'(cout), W'(1));
`else
        check("sub_pos_const", sum, 64'd12);
`endif

        // Reset while in RUN at idx = 2
        send(64'hAAAA_BBBB_CCCC_DDDD, 64'h1111_2222_3333_4444, 1'b0, acc);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        if (exp_q.size() != 0) void'(exp_q.pop_back());
        check("abort_busy", W'(busy), W'(0));
        check("abort_valid", W'(out_valid), W'(0));
        check("abort_sum", sum, W'(0));
        check("abort_cout", W'(cout), W'(0));
        check("abort_in_ready", W'(in_ready), W'(1));
        repeat (5) @(negedge clk);
        check("abort_no_valid", W'(out_valid), W'(0));
        send(64'h1234, 64'h1, 1'b0, acc);
        receive("after_abort", acc, 0);
        check("after_abort_const", sum, 64'h1235);

        // Back-to-back traffic, in_valid held high and out_ready = 1
        bb_a[0] = 64'hDEAD_BEEF_0000_FFFF;  bb_b[0] = 64'h0000_0000_FFFF_0001;
        bb_a[1] = 64'h7FFF_FFFF_FFFF_FFFF;  bb_b[1] = 64'h0000_0000_0000_0001;
        bb_a[2] = 64'hF0F0_F0F0_F0F0_F0F0;  bb_b[2] = 64'h0F0F_0F0F_0F0F_0F10;
        sent      = 0;
        got       = 0;
        last_acc  = 0;
        upd       = 1'b0;
        a         = bb_a[0];
        b         = bb_b[0];
        sub       = 1'b0;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        for (int n = 0; n < 100 && got < 3; n++) begin
            if (upd) begin
                a   = bb_a[sent];
                b   = bb_b[sent];
                upd = 1'b0;
            end
            if (sent == 3) in_valid = 1'b0;
            if (out_valid) begin
                compare_head("b2b");
                got++;
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(model(a, b, sub));
                if (sent > 0) check("b2b_spacing", W'(cyc + 1 - last_acc), W'(NW + 2));
                last_acc = cyc + 1;
                sent++;
                if (sent < 3) upd = 1'b1;
            end
            @(negedge clk);
        end
        check("b2b_count", W'(got), W'(3));
        in_valid  = 1'b0;
        out_ready = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/wide_add_sequencer.md
# wide_add_sequencer

Multi-cycle wide-operand adder controller. It accepts one NUM_WORDS×DATA_SIZE-bit add (or subtract) request over a valid/ready handshake. It sequences one DATA_SIZE-bit chunk per cycle through an internal DATA_SIZE-bit prefix chunk adder, least-significant chunk first, chaining the carry between chunks. It returns the full-width sum and carry-out over a second valid/ready handshake, letting the datapath support 64-bit arithmetic while keeping only a 16-bit prefix adder.

## Interface
- DATA_SIZE, 16, chunk width in bits (width of the prefix chunk adder)
- NUM_WORDS, 4, number of chunks per operand, ≥2; W = DATA_SIZE*NUM_WORDS
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  request valid
- in_ready  output  1  block can accept a request
- a  input  W  operand A
- b  input  W  operand B
- sub  input  1  1 = compute a−b (only with WIDE_ADD_SUB_EN)
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- sum  output  W  result, registered
- cout  output  1  final carry-out (for subtract: 1 = no borrow)
- busy  output  1  state != IDLE

## Operation
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready = 1 when reset = 0.
  - On in_valid && in_ready: latch a, b, and the effective sub into operand registers; idx ← 0; carry ← effective sub; go to RUN.
- RUN, each cycle:
  - Chunk add: s_chunk = a[idx] + (b[idx] XOR {DATA_SIZE{sub}}) + carry, computed by the prefix chunk adder with carry-in.
  - sum[idx*DATA_SIZE +: DATA_SIZE] ← s_chunk; carry ← chunk carry-out.
  - If idx == NUM_WORDS−1: cout ← chunk carry-out; go to DONE. Otherwise idx ← idx+1.
- DONE:
  - out_valid = 1.
  - On out_ready: go to IDLE. sum and cout hold their values until the next request overwrites them.
- in_ready is 0 in RUN and DONE; requests are never queued.
- Arithmetic is modulo 2^W. No overflow flag. Chunk carry is 1 bit; idx is $clog2(NUM_WORDS) bits and never wraps mid-operation.
- sum chunks not yet written during RUN keep their previous values; they are only meaningful in DONE.
- Input operand ports are sampled only on the accept edge; later changes have no effect.

## Timing
- Reset (synchronous):
  - state = IDLE, idx = 0, carry = 0, sum = 0, cout = 0, out_valid = 0, busy = 0.
  - in_ready = 0 while reset is high and 1 in the first cycle after.
- Reset mid-operation (RUN or DONE) aborts the operation. The partial result is discarded (sum = 0) and no out_valid is produced.
- Latency: request accepted at edge T0; out_valid rises after edge T0+NUM_WORDS (4 cycles by default).
- out_valid stays high, with sum and cout stable, until out_ready is sampled high. The transition to IDLE occurs on that edge.
- Minimum initiation interval: NUM_WORDS+2 cycles (accept, NUM_WORDS RUN cycles, DONE/handshake, then IDLE to accept again).
- in_valid asserted while in_ready = 0 is ignored. The requester must hold the request until it sees in_ready.
- The critical path is one chunk adder plus the carry register; there is no full-width combinational carry path.

## Configuration
- WIDE_ADD_SUB_EN defined:
  - Effective sub = sub input.
  - b chunks are inverted and the initial carry is 1, so the block computes a−b in two's complement.
- WIDE_ADD_SUB_EN undefined:
  - Effective sub is tied to 0 and the sub input is ignored; the block always computes a+b with an initial carry of 0.
  - The XOR inversion logic is not synthesized.

## Test plan
- Defaults (16×4). a = 0x0000_0000_0000_FFFF, b = 0x1 → sum = 0x0000_0000_0001_0000, cout = 0; out_valid rises exactly 4 cycles after accept.
- a = 0xFFFF_FFFF_FFFF_FFFF, b = 0x1 → sum = 0, cout = 1 (carry propagates through all chunks).
- out_ready held low for 3 cycles in DONE, with a second in_valid asserted → sum and cout stable, in_ready = 0, second request not accepted until the IDLE cycle after the handshake.
- With WIDE_ADD_SUB_EN:
  - a = 5, b = 7, sub = 1 → sum = 0xFFFF_FFFF_FFFF_FFFE, cout = 0.
  - a = 7, b = 5, sub = 1 → sum = 2, cout = 1.
- Without WIDE_ADD_SUB_EN: a = 5, b = 7, sub = 1 → sum = 12.
- reset asserted for 1 cycle while in RUN at idx = 2 → next cycle state = IDLE, out_valid = 0, sum = 0, cout = 0. A following request 0x1234 + 0x1 → sum = 0x1235.
- Back-to-back traffic with in_valid held high and out_ready = 1 → accepts spaced exactly 6 cycles apart; each result matches its own operands.
